// File: rtl/btpo_pkg.sv
// Shared types and sizing helpers for the block-throttled pipe-out arbiter.
package btpo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int HDR_ID_W  = 4;
    localparam int HDR_CNT_W = 12;

    // One extra bit so the counter can represent BLOCK_LEN itself.
    function automatic int word_cnt_w(input int block_len);
        return $clog2(block_len) + 1;
    endfunction

endpackage

// File: rtl/btpipe_out_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible source after last_grant, wrapping.
module rr_pick #(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] eligible,
    input  logic [2:0]       last_grant,
    output logic [2:0]       grant,
    output logic             valid
);

    int c;

    // Walk the search order backwards so the nearest candidate is the last write.
    always_comb begin
        grant = last_grant;
        valid = 1'b0;
        c     = 0;
        for (int i = N_SRC; i >= 1; i--) begin
            c = (int'(last_grant) + i) % N_SRC;
            if (eligible[c]) begin
                grant = 3'(c);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/btpipe_out_arbiter.sv
// Arbitrates N_SRC source FIFOs onto one block-throttled pipe-out endpoint.
// Optional block header word enabled by defining BTPO_HEADER_EN.
module btpipe_out_arbiter
    import btpo_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int BLOCK_LEN = 256,
    parameter int LVL_W     = 11
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_SRC-1:0]       src_enable,
    input  logic [N_SRC*LVL_W-1:0] src_level,
    input  logic [N_SRC*16-1:0]    src_data,
    output logic [N_SRC-1:0]       src_rd,
    input  logic                   ep_read,
    input  logic                   ep_blockstrobe,
    output logic                   ep_ready,
    output logic [15:0]            ep_datain,
    output logic [2:0]             grant_id,
    output logic [15:0]            blocks_sent,
    output logic                   err_proto
);

    localparam int CW = word_cnt_w(BLOCK_LEN);
`ifdef BTPO_HEADER_EN
    localparam int THRESH = BLOCK_LEN - 1;
`else
    localparam int THRESH = BLOCK_LEN;
`endif

    state_t           state;
    logic [2:0]       last_grant;
    logic [CW-1:0]    word_cnt;
    logic             rd_d;
    logic [15:0]      last_word;
    logic [15:0]      gdata;
    logic [N_SRC-1:0] eligible;
    logic [2:0]       pick;
    logic             pick_valid;
    logic             xfer_rd;
    logic             src_fetch;
`ifdef BTPO_HEADER_EN
    logic             hdr_slot;
    logic             hdr_d;
`endif

    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_SRC; i++) begin
            eligible[i] = src_enable[i] &&
                ({1'b0, src_level[i*LVL_W +: LVL_W]} >= (LVL_W+1)'(THRESH));
        end
    end

    rr_pick #(.N_SRC(N_SRC)) u_rr_pick (
        .eligible   (eligible),
        .last_grant (last_grant),
        .grant      (pick),
        .valid      (pick_valid)
    );

    assign xfer_rd = (state == XFER) && ep_read;
`ifdef BTPO_HEADER_EN
    assign hdr_slot  = (word_cnt == '0);
    assign src_fetch = xfer_rd && !hdr_slot;
`else
    assign src_fetch = xfer_rd;
`endif

    always_comb begin
        src_rd = '0;
        gdata  = 16'h0000;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_id == 3'(i)) begin
                src_rd[i] = src_fetch;
                gdata     = src_data[i*16 +: 16];
            end
        end
    end

    // Source data arrives one cycle after its read strobe; otherwise hold the last word.
    always_comb begin
        if (rd_d) begin
            ep_datain = gdata;
        end else begin
            ep_datain = last_word;
        end
`ifdef BTPO_HEADER_EN
        if (hdr_d) begin
            ep_datain = {HDR_ID_W'(grant_id), blocks_sent[HDR_CNT_W-1:0]};
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant_id    <= 3'(N_SRC - 1);
            last_grant  <= 3'(N_SRC - 1);
            ep_ready    <= 1'b0;
            word_cnt    <= '0;
            blocks_sent <= 16'h0000;
            err_proto   <= 1'b0;
            rd_d        <= 1'b0;
            last_word   <= 16'h0000;
`ifdef BTPO_HEADER_EN
            hdr_d       <= 1'b0;
`endif
        end else begin
            rd_d      <= src_fetch;
            last_word <= ep_datain;
`ifdef BTPO_HEADER_EN
            hdr_d     <= xfer_rd && hdr_slot;
`endif
            if ((ep_read && (state == IDLE || state == ARMED)) ||
                (ep_blockstrobe && state == XFER)) begin
                err_proto <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick;
                        ep_ready <= 1'b1;
                        state    <= ARMED;
                    end
                end
                ARMED: begin
                    if (ep_blockstrobe) begin
                        ep_ready <= 1'b0;
                        word_cnt <= '0;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (ep_read) begin
                        if (word_cnt == CW'(BLOCK_LEN - 1)) begin
                            word_cnt <= '0;
                            state    <= DONE;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    blocks_sent <= blocks_sent + 16'd1;
                    last_grant  <= grant_id;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/btpipe_out_arbiter.md
BTPIPE_OUT_ARBITER -- requirements
Module: btpipe_out_arbiter

Interface
REQ-001 The block SHALL have parameter N_SRC, default 4: number of data sources sharing one block-throttled pipe-out endpoint (2..8).
REQ-002 The block SHALL have parameter BLOCK_LEN, default 256: words per pipe block (power of two, 4..1024).
REQ-003 The block SHALL have parameter LVL_W, default 11: width of each source fill-level field.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset; polarity and synchronicity are fixed.
REQ-005 The block SHALL have port clk, input, 1: endpoint clock (ti_clk domain).
REQ-006 The block SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-007 The block SHALL have port src_enable, input, N_SRC: per-source enable from a wire-in.
REQ-008 The block SHALL have port src_level, input, N_SRC*LVL_W: words available per source FIFO.
REQ-009 The block SHALL have port src_data, input, N_SRC*16: source FIFO read data, one-cycle read latency.
REQ-010 The block SHALL have port src_rd, output, N_SRC: per-source FIFO read strobe.
REQ-011 The block SHALL have port ep_read, input, 1: endpoint read strobe.
REQ-012 The block SHALL have port ep_blockstrobe, input, 1: endpoint block-start strobe.
REQ-013 The block SHALL have port ep_ready, output, 1: a full block is committed.
REQ-014 The block SHALL have port ep_datain, output, 16: data to the endpoint.
REQ-015 The block SHALL have port grant_id, output, 3: currently granted source.
REQ-016 The block SHALL have port blocks_sent, output, 16: completed-block counter, wraps at 0xFFFF->0.
REQ-017 The block SHALL have port err_proto, output, 1: sticky protocol-error flag.

Function
REQ-018 The FSM SHALL have states IDLE, ARMED, XFER and DONE.
REQ-019 A source SHALL be eligible when src_enable[i]=1 and src_level[i] >= BLOCK_LEN (BLOCK_LEN-1 with the header feature enabled).
REQ-020 In IDLE, the FSM SHALL grant the first eligible source searching round-robin from last_grant+1 (wrapping) and go to ARMED the next cycle; it SHALL stay in IDLE if none is eligible.
REQ-021 In ARMED, ep_ready SHALL be 1; on ep_blockstrobe=1, the FSM SHALL go to XFER and ep_ready SHALL be 0 from the next cycle.
REQ-022 In XFER, src_rd[grant_id] SHALL equal ep_read combinationally and all other src_rd bits SHALL be 0.
REQ-023 In XFER, ep_datain SHALL equal src_data[grant_id]: valid the cycle after ep_read, per the FIFO latency.
REQ-024 A word counter SHALL increment on each ep_read; the read making count=BLOCK_LEN SHALL move the FSM to DONE.
REQ-025 DONE SHALL last one cycle: increment blocks_sent, set last_grant to grant_id, return to IDLE.
REQ-026 In DONE and IDLE, ep_datain SHALL hold the last word for one cycle.
REQ-027 Deassertion of src_enable[grant_id] in ARMED SHALL NOT revoke the grant; the block SHALL complete.
REQ-028 ep_read in IDLE or ARMED, or ep_blockstrobe in XFER, SHALL set err_proto, be otherwise ignored, and SHALL NOT pulse src_rd.
REQ-029 err_proto SHALL clear only on reset.
REQ-030 grant_id SHALL be stable from ARMED through DONE.

Reset
REQ-031 On reset_n=0, the block SHALL go to IDLE asynchronously.
REQ-032 On reset, ep_ready, src_rd, ep_datain, blocks_sent, err_proto and the word counter SHALL be 0.
REQ-033 On reset, grant_id and last_grant SHALL be N_SRC-1 so that source 0 is searched first.
REQ-034 A reset mid-block SHALL abandon the block with no further src_rd.

Configuration
REQ-035 With BTPO_HEADER_EN defined, the first word of each block SHALL be the header {grant_id[3:0], blocks_sent[11:0]}.
REQ-036 With BTPO_HEADER_EN defined, the first ep_read of a block SHALL NOT pulse src_rd, and exactly BLOCK_LEN-1 source words SHALL follow the header.
REQ-037 Without BTPO_HEADER_EN, all BLOCK_LEN words SHALL be source data and the eligibility threshold SHALL be BLOCK_LEN.

Structure
REQ-038 A shared package btpo_pkg SHALL hold the FSM state enum, the header field widths and the function that computes the word-counter width from BLOCK_LEN.
REQ-039 The round-robin search SHALL be a sub-module rr_pick (inputs eligible mask and last_grant; outputs grant index and valid), combinational only.

Verification
REQ-040 With source 2 only eligible (level 300, BLOCK_LEN 256): strobe then 256 reads -> exactly 256 src_rd[2] pulses, blocks_sent=1, ep_ready low after the strobe.
REQ-041 With all four sources eligible continuously: 8 blocks -> grant_id sequence 0,1,2,3,0,1,2,3.
REQ-042 With src_enable[1] dropped during ARMED of source 1 -> block completes from source 1; the next grant skips source 1.
REQ-043 A read in ARMED before the strobe -> err_proto=1, no src_rd pulse, the following block is unaffected.
REQ-044 reset_n low after 100 reads of a block -> IDLE immediately, src_rd=0, blocks_sent=0; after release, grant source 0 first.
REQ-045 With BTPO_HEADER_EN and block 5 from source 3: first word 0x3005, then 255 source words, level threshold 255.
